// File: rtl/viterbi_ber_checker.sv
// -----------------------------------------------------------------------------
// viterbi_ber_checker
//
// Purpose:
//   Bit-error-rate checker for the Viterbi decode path. It compares the
//   original transmit bit stream against the decoder output and searches for
//   the decoder's unknown pipeline latency. Once aligned, it counts the
//   compared bits and the bit errors. It drops lock when a window contains too
//   many errors.
//
// Ports:
//   CLOCK      in   single clock, all logic on the rising edge
//   Reset      in   synchronous active-high reset (overrides Enable)
//   Enable     in   run when high; low forces IDLE
//   BitValid   in   one-cycle strobe per data bit (gated by Enable)
//   RefBit     in   transmitted bit, sampled when a bit is valid
//   DecBit     in   decoder output bit, sampled when a bit is valid
//   Locked     out  alignment found
//   LockDelay  out  current candidate / locked delay in bits
//   BitCount   out  bits compared while locked (saturating)
//   ErrCount   out  mismatches while locked (saturating)
//   ErrStrobe  out  one-cycle pulse per counted error
// -----------------------------------------------------------------------------
module viterbi_ber_checker #(
    parameter int MAX_LAT  = 32,
    parameter int SYNC_WIN = 16,
    parameter int LOSS_THR = 4,
    parameter int CNT_W    = 16
) (
    input  logic                       CLOCK,
    input  logic                       Reset,
    input  logic                       Enable,
    input  logic                       BitValid,
    input  logic                       RefBit,
    input  logic                       DecBit,
    output logic                       Locked,
    output logic [$clog2(MAX_LAT)-1:0] LockDelay,
    output logic [CNT_W-1:0]           BitCount,
    output logic [CNT_W-1:0]           ErrCount,
    output logic                       ErrStrobe
);

    localparam int DLY_W = $clog2(MAX_LAT);
    localparam int WIN_W = $clog2(SYNC_WIN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_LOCKED
    } state_t;

    state_t             r_state;
    logic [MAX_LAT-2:0] r_hist;
    logic [DLY_W-1:0]   r_delay;
    logic [WIN_W-1:0]   r_mc;
    logic [WIN_W-1:0]   r_wc;
    logic [WIN_W-1:0]   r_we;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_err_strobe;

    state_t             w_state_next;
    logic [DLY_W-1:0]   w_delay_next;
    logic [WIN_W-1:0]   w_mc_next;
    logic [WIN_W-1:0]   w_wc_next;
    logic [WIN_W-1:0]   w_we_next;
    logic [CNT_W-1:0]   w_bit_cnt_next;
    logic [CNT_W-1:0]   w_err_cnt_next;
    logic               w_err_strobe_next;

    logic               w_valid;
    logic [MAX_LAT-1:0] w_taps;
    logic               w_ref_d;
    logic               w_mis;
    logic [WIN_W-1:0]   w_mc_inc;
    logic [WIN_W-1:0]   w_we_total;

    assign w_valid = Enable & BitValid;

    // Tap 0 is the live reference bit, tap d (d>0) is the bit received d valid
    // bits ago. Indexing one vector keeps the delay select in range for every
    // LockDelay value.
    assign w_taps  = {r_hist, RefBit};
    assign w_ref_d = w_taps[r_delay];
    assign w_mis   = w_ref_d ^ DecBit;

    assign w_mc_inc   = r_mc + WIN_W'(1);
    // Error total of the window including the bit being compared right now.
    assign w_we_total = r_we + {{(WIN_W-1){1'b0}}, w_mis};

    always_comb begin
        w_state_next      = r_state;
        w_delay_next      = r_delay;
        w_mc_next         = r_mc;
        w_wc_next         = r_wc;
        w_we_next         = r_we;
        w_bit_cnt_next    = r_bit_cnt;
        w_err_cnt_next    = r_err_cnt;
        w_err_strobe_next = 1'b0;

        if (!Enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_SEARCH;
                    w_mc_next    = '0;
                end

                S_SEARCH: begin
                    if (w_valid) begin
                        if (!w_mis) begin
                            w_mc_next = w_mc_inc;
                            if (w_mc_inc == WIN_W'(SYNC_WIN)) begin
                                w_state_next   = S_LOCKED;
                                w_bit_cnt_next = '0;
                                w_err_cnt_next = '0;
                                w_wc_next      = '0;
                                w_we_next      = '0;
                            end
                        end else begin
                            // Wrong candidate: try the next delay (wraps
                            // naturally because MAX_LAT is a power of two).
                            w_mc_next    = '0;
                            w_delay_next = r_delay + DLY_W'(1);
                        end
                    end
                end

                S_LOCKED: begin
                    if (w_valid) begin
                        if (!(&r_bit_cnt)) begin
                            w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                        end
                        if (w_mis) begin
                            w_err_strobe_next = 1'b1;
                            if (!(&r_err_cnt)) begin
                                w_err_cnt_next = r_err_cnt + CNT_W'(1);
                            end
                        end
                        if (r_wc == WIN_W'(SYNC_WIN - 1)) begin
                            w_wc_next = '0;
                            w_we_next = '0;
                            if (w_we_total >= WIN_W'(LOSS_THR)) begin
                                // Loss of lock; counters hold until next lock.
                                w_state_next = S_SEARCH;
                                w_delay_next = r_delay + DLY_W'(1);
                                w_mc_next    = '0;
                            end
                        end else begin
                            w_wc_next = r_wc + WIN_W'(1);
                            w_we_next = w_we_total;
                        end
                    end
                end

                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_hist       <= '0;
            r_delay      <= '0;
            r_mc         <= '0;
            r_wc         <= '0;
            r_we         <= '0;
            r_bit_cnt    <= '0;
            r_err_cnt    <= '0;
            r_err_strobe <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_delay      <= w_delay_next;
            r_mc         <= w_mc_next;
            r_wc         <= w_wc_next;
            r_we         <= w_we_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_err_cnt    <= w_err_cnt_next;
            r_err_strobe <= w_err_strobe_next;
            if (w_valid) begin
                r_hist <= {r_hist[MAX_LAT-3:0], RefBit};
            end
        end
    end

    assign Locked    = (r_state == S_LOCKED);
    assign LockDelay = r_delay;
    assign BitCount  = r_bit_cnt;
    assign ErrCount  = r_err_cnt;
    assign ErrStrobe = r_err_strobe;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// -----------------------------------------------------------------------------
// tb_viterbi_ber_checker
//
// Purpose:
//   Self-checking bench for viterbi_ber_checker. Two instances share the same
//   stimulus: one with default parameters and one with 4-bit counters and a
//   loss threshold equal to the window length. A behavioural model, built on
//   a queue of sent reference bits and integer counters, predicts both.
// -----------------------------------------------------------------------------
module tb_viterbi_ber_checker;

    localparam int ML   = 32;
    localparam int SW   = 16;
    localparam int CAP1 = 65535;
    localparam int CAP2 = 15;
    localparam int THR1 = 4;
    localparam int THR2 = 16;

    logic        CLOCK = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic        BitValid = 1'b0;
    logic        RefBit = 1'b0;
    logic        DecBit = 1'b0;

    logic        Locked1, Locked2;
    logic [4:0]  LockDelay1, LockDelay2;
    logic [15:0] BitCount1, ErrCount1;
    logic [3:0]  BitCount2, ErrCount2;
    logic        ErrStrobe1, ErrStrobe2;

    always #5 CLOCK = ~CLOCK;

    viterbi_ber_checker #(
        .MAX_LAT(ML), .SYNC_WIN(SW), .LOSS_THR(THR1), .CNT_W(16)
    ) u_dut1 (
        .CLOCK(CLOCK), .Reset(Reset), .Enable(Enable), .BitValid(BitValid),
        .RefBit(RefBit), .DecBit(DecBit), .Locked(Locked1),
        .LockDelay(LockDelay1), .BitCount(BitCount1), .ErrCount(ErrCount1),
        .ErrStrobe(ErrStrobe1)
    );

    viterbi_ber_checker #(
        .MAX_LAT(ML), .SYNC_WIN(SW), .LOSS_THR(THR2), .CNT_W(4)
    ) u_dut2 (
        .CLOCK(CLOCK), .Reset(Reset), .Enable(Enable), .BitValid(BitValid),
        .RefBit(RefBit), .DecBit(DecBit), .Locked(Locked2),
        .LockDelay(LockDelay2), .BitCount(BitCount2), .ErrCount(ErrCount2),
        .ErrStrobe(ErrStrobe2)
    );

    // Model: st 0=idle, 1=search, 2=locked
    typedef struct {
        int st;
        int dly;
        int mc;
        int wc;
        int we;
        int bits;
        int errs;
        int strobe;
    } model_t;

    model_t m1, m2;
    bit     sent[$];        // valid reference bits since reset, newest last
    int     tx_dly;         // latency applied to build DecBit
    bit [6:0] lfsr = 7'h5A;
    int     nvalid = 0;
    int     s1 = 0, s2 = 0; // observed strobe pulses
    int     total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference bit seen d valid bits ago (d=0: live bit); unfilled reads 0.
    function automatic bit refd(input int d, input bit rb);
        if (d == 0) return rb;
        if (sent.size() < d) return 1'b0;
        return sent[sent.size() - d];
    endfunction

    function automatic model_t mstep(input model_t m, input bit en, input bit v,
                                     input bit mis, input int cap, input int thr);
        model_t n;
        n = m;
        n.strobe = 0;
        if (!en) begin
            n.st = 0;
        end else if (m.st == 0) begin
            n.st = 1;
            n.mc = 0;
        end else if (m.st == 1 && v) begin
            if (!mis) begin
                n.mc = m.mc + 1;
                if (n.mc == SW) begin
                    n.st = 2; n.bits = 0; n.errs = 0; n.wc = 0; n.we = 0;
                end
            end else begin
                n.mc  = 0;
                n.dly = (m.dly + 1) % ML;
            end
        end else if (m.st == 2 && v) begin
            n.bits = (m.bits == cap) ? cap : m.bits + 1;
            if (mis) begin
                n.errs   = (m.errs == cap) ? cap : m.errs + 1;
                n.strobe = 1;
            end
            if (m.wc == SW - 1) begin
                n.wc = 0;
                n.we = 0;
                if (m.we + int'(mis) >= thr) begin
                    n.st  = 1;
                    n.dly = (m.dly + 1) % ML;
                    n.mc  = 0;
                end
            end else begin
                n.wc = m.wc + 1;
                n.we = m.we + int'(mis);
            end
        end
        return n;
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic tick(input bit rst_i, input bit en_i, input bit v_i, input bit fl);
        bit rb, db, mis1, mis2, nb;
        if (en_i && v_i) begin
            nb   = lfsr[6] ^ lfsr[5];
            lfsr = {lfsr[5:0], nb};
            rb   = nb;
            db   = refd(tx_dly, rb) ^ fl;
        end else begin
            rb = 1'($urandom_range(0, 1));
            db = 1'($urandom_range(0, 1));
        end
        Reset = rst_i; Enable = en_i; BitValid = v_i; RefBit = rb; DecBit = db;
        @(posedge CLOCK);
        if (rst_i) begin
            m1 = '{default: 0};
            m2 = '{default: 0};
            sent.delete();
        end else begin
            mis1 = refd(m1.dly, rb) ^ db;
            mis2 = refd(m2.dly, rb) ^ db;
            m1 = mstep(m1, en_i, v_i, mis1, CAP1, THR1);
            m2 = mstep(m2, en_i, v_i, mis2, CAP2, THR2);
            if (en_i && v_i) begin
                sent.push_back(rb);
                if (sent.size() > 64) void'(sent.pop_front());
                nvalid++;
            end
        end
        #1;
        if (ErrStrobe1 === 1'b1) s1++;
        if (ErrStrobe2 === 1'b1) s2++;
        chk("locked1", 32'(Locked1), 32'(m1.st == 2));
        chk("delay1", 32'(LockDelay1), m1.dly);
        chk("bits1", 32'(BitCount1), m1.bits);
        chk("errs1", 32'(ErrCount1), m1.errs);
        chk("strobe1", 32'(ErrStrobe1), m1.strobe);
        chk("locked2", 32'(Locked2), 32'(m2.st == 2));
        chk("delay2", 32'(LockDelay2), m2.dly);
        chk("bits2", 32'(BitCount2), m2.bits);
        chk("errs2", 32'(ErrCount2), m2.errs);
        chk("strobe2", 32'(ErrStrobe2), m2.strobe);
    endtask

    task automatic wait_lock(input int which, input int budget, input string tag);
        int n;
        n = 0;
        while (n < budget && !((which == 1) ? (Locked1 === 1'b1) : (Locked2 === 1'b1))) begin
            tick(1'b0, 1'b1, ($urandom_range(0, 3) != 0), 1'b0);
            n++;
        end
        chk(tag, 32'((which == 1) ? Locked1 : Locked2), 32'd1);
    endtask

    task automatic restart(input int d);
        tx_dly = d;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int base, held, eb;
        m1 = '{default: 0};
        m2 = '{default: 0};
        tx_dly = 5;
        lfsr = 7'($urandom_range(1, 127));

        // Reset state
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_locked", 32'(Locked1), 0);
        chk("rst_delay", 32'(LockDelay1), 0);
        chk("rst_bits", 32'(BitCount1), 0);
        chk("rst_errs", 32'(ErrCount1), 0);
        $display("reset: locked=%0d delay=%0d", Locked1, LockDelay1);

        // 1: clean stream at delay 5
        restart(5);
        wait_lock(1, 3000, "t1_lock");
        chk("t1_delay", 32'(LockDelay1), 5);
        base = nvalid; s1 = 0;
        for (int k = 0; k < 20000 && nvalid - base < 1000; k++)
            tick(1'b0, 1'b1, ($urandom_range(0, 3) != 0), 1'b0);
        chk("t1_bits", 32'(BitCount1), 1000);
        chk("t1_errs", 32'(ErrCount1), 0);
        chk("t1_strobes", s1, 0);
        $display("t1: delay=%0d bits=%0d errs=%0d", LockDelay1, BitCount1, ErrCount1);

        // 2: three isolated errors
        for (int i = 0; i < 150; i++)
            tick(1'b0, 1'b1, 1'b1, (i == 20 || i == 60 || i == 100));
        chk("t2_errs", 32'(ErrCount1), 3);
        chk("t2_strobes", s1, 3);
        chk("t2_locked", 32'(Locked1), 1);
        chk("t2_bits", 32'(BitCount1), 1150);
        $display("t2: errs=%0d strobes=%0d locked=%0d", ErrCount1, s1, Locked1);

        // 3: four errors in one window -> loss, then relock after wrap
        for (int k = 0; k < 32 && m1.wc != 0; k++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b1, 1'b1, (i < 4));
            if (i == 14) chk("t3_still_locked", 32'(Locked1), 1);
        end
        eb = nvalid - base;
        chk("t3_lost", 32'(Locked1), 0);
        chk("t3_delay", 32'(LockDelay1), 6);
        chk("t3_bits", 32'(BitCount1), eb);
        chk("t3_errs", 32'(ErrCount1), 7);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_bits_hold", 32'(BitCount1), eb);
        chk("t3_errs_hold", 32'(ErrCount1), 7);
        wait_lock(1, 6000, "t3_relock");
        chk("t3_redelay", 32'(LockDelay1), 5);
        chk("t3_rebits", 32'(BitCount1), 0);
        chk("t3_reerrs", 32'(ErrCount1), 0);
        $display("t3: relocked delay=%0d bits=%0d", LockDelay1, BitCount1);

        // 4: boundary delays 31 and 0
        restart(31);
        wait_lock(1, 6000, "t4_lock31");
        chk("t4_delay31", 32'(LockDelay1), 31);
        restart(0);
        for (int i = 1; i <= 16; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0);
            chk("t4_lock0_edge", 32'(Locked1), 32'(i == 16));
        end
        chk("t4_delay0", 32'(LockDelay1), 0);
        $display("t4: delay31 and delay0 locked, delay=%0d", LockDelay1);

        // 5: saturation on the 4-bit instance under permanent inversion
        restart(7);
        wait_lock(2, 3000, "t5_lock");
        s2 = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b1);
            if (i == 14) begin
                chk("t5_sat_bits", 32'(BitCount2), 15);
                chk("t5_sat_errs", 32'(ErrCount2), 15);
                chk("t5_sat_locked", 32'(Locked2), 1);
            end
        end
        chk("t5_lost", 32'(Locked2), 0);
        chk("t5_bits", 32'(BitCount2), 15);
        chk("t5_errs", 32'(ErrCount2), 15);
        chk("t5_delay", 32'(LockDelay2), 8);
        chk("t5_strobes", s2, 16);
        $display("t5: bits=%0d errs=%0d strobes=%0d", BitCount2, ErrCount2, s2);

        // 6: reset while locked, then Enable drop during search
        restart(9);
        wait_lock(1, 3000, "t6_lock");
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t6_rst_locked", 32'(Locked1), 0);
        chk("t6_rst_delay", 32'(LockDelay1), 0);
        chk("t6_rst_bits", 32'(BitCount1), 0);
        chk("t6_rst_errs", 32'(ErrCount1), 0);
        chk("t6_rst_strobe", 32'(ErrStrobe1), 0);
        restart(10);
        for (int k = 0; k < 2000 && LockDelay1 !== 5'd4; k++)
            tick(1'b0, 1'b1, ($urandom_range(0, 3) != 0), 1'b0);
        held = 4;
        chk("t6_mid_delay", 32'(LockDelay1), held);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_idle_delay", 32'(LockDelay1), held);
        chk("t6_idle_locked", 32'(Locked1), 0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_resume_delay", 32'(LockDelay1), held);
        wait_lock(1, 3000, "t6_relock");
        chk("t6_final_delay", 32'(LockDelay1), 10);
        $display("t6: resumed from %0d, locked at %0d", held, LockDelay1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
